// File: rtl/mem_stage_dm.sv
// MEM-stage data memory and load/store unit for the 5-stage MIPS pipeline.
// Word-organised little-endian RAM with combinational extended loads,
// byte/halfword/word stores merged into the addressed word, and a
// registered store-trace port for the commit log.
module mem_stage_dm #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_pc_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_addr_err_o,
  output logic        wr_valid_o,
  output logic [31:0] wr_pc_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem [DEPTH_WORDS];

  logic [5:0]          opcode;
  logic [IDX_BITS-1:0] word_idx;
  logic [31:0]         rd_word;
  logic                is_load;
  logic                is_store;
  logic                acc_word;
  logic                acc_half;
  logic                sign_ext;
  logic                range_err;
  logic                align_err;
  logic                addr_err;
  logic                commit;
  logic [15:0]         half_lane;
  logic [7:0]          byte_lane;
  logic [31:0]         merged;
  logic                unused_instr_bits;

  assign opcode            = mem_instr_i[31:26];
  assign unused_instr_bits = ^mem_instr_i[25:0];
  assign word_idx          = mem_addr_i[ADDR_BITS-1:2];
  assign rd_word           = mem[word_idx];

  // Decode the opcode into access kind, width and extension mode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_word = 1'b0;
    acc_half = 1'b0;
    sign_ext = 1'b0;
    case (opcode)
      OP_LW:  begin is_load = 1'b1; acc_word = 1'b1; end
      OP_LH:  begin is_load = 1'b1; acc_half = 1'b1; sign_ext = 1'b1; end
      OP_LHU: begin is_load = 1'b1; acc_half = 1'b1; end
      OP_LB:  begin is_load = 1'b1; sign_ext = 1'b1; end
      OP_LBU: begin is_load = 1'b1; end
      OP_SW:  begin is_store = 1'b1; acc_word = 1'b1; end
      OP_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; end
      default: begin end
    endcase
  end

  assign range_err = ({1'b0, mem_addr_i} >= MEM_BYTES);
  assign align_err = (acc_word && (mem_addr_i[1:0] != 2'b00)) ||
                     (acc_half && mem_addr_i[0]);
  assign addr_err  = (is_load || is_store) && (range_err || align_err);
  assign commit    = is_store && !addr_err;

  assign mem_addr_err_o = addr_err;

  // Select the halfword and byte lanes addressed within the current word
  always_comb begin
    half_lane = mem_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    byte_lane = rd_word[7:0];
    case (mem_addr_i[1:0])
      2'd0: byte_lane = rd_word[7:0];
      2'd1: byte_lane = rd_word[15:8];
      2'd2: byte_lane = rd_word[23:16];
      2'd3: byte_lane = rd_word[31:24];
      default: byte_lane = rd_word[7:0];
    endcase
  end

  // Extend the selected lane into the load result; faulting loads return 0
  always_comb begin
    mem_rdata_o = 32'h0;
    if (is_load && !addr_err) begin
      if (acc_word) begin
        mem_rdata_o = rd_word;
      end else if (acc_half) begin
        mem_rdata_o = {{16{sign_ext & half_lane[15]}}, half_lane};
      end else begin
        mem_rdata_o = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
    end
  end

  // Merge the store data into the old word, keeping untouched lanes
  always_comb begin
    merged = rd_word;
    if (acc_word) begin
      merged = mem_wdata_i;
    end else if (acc_half) begin
      if (mem_addr_i[1]) merged[31:16] = mem_wdata_i[15:0];
      else               merged[15:0]  = mem_wdata_i[15:0];
    end else begin
      case (mem_addr_i[1:0])
        2'd0: merged[7:0]   = mem_wdata_i[7:0];
        2'd1: merged[15:8]  = mem_wdata_i[7:0];
        2'd2: merged[23:16] = mem_wdata_i[7:0];
        2'd3: merged[31:24] = mem_wdata_i[7:0];
        default: merged = rd_word;
      endcase
    end
  end

  // One register per word so the whole array clears in a single reset cycle
  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset) begin
        mem[g] <= 32'h0;
      end else if (commit && (word_idx == IDX_BITS'(g))) begin
        mem[g] <= merged;
      end
    end
  end

  // Store-trace registers: pulse valid after a commit, hold payload otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_o <= 1'b0;
      wr_pc_o    <= 32'h0;
      wr_addr_o  <= 32'h0;
      wr_data_o  <= 32'h0;
    end else begin
      wr_valid_o <= commit;
      if (commit) begin
        wr_pc_o   <= mem_pc_i;
        wr_addr_o <= {mem_addr_i[31:2], 2'b00};
        wr_data_o <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Self-checking bench for mem_stage_dm: directed test-plan sequences followed
// by random load/store traffic, compared against a behavioural memory model.
module tb_mem_stage_dm;

  localparam int DEPTH = 1024;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_instr_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_rdata_o;
  logic        mem_addr_err_o;
  logic        wr_valid_o;
  logic [31:0] wr_pc_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;

  int vectors;
  int miscompares;

  logic [31:0] model_mem [DEPTH];
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          valid_pulses;

  mem_stage_dm #(.DEPTH_WORDS(DEPTH), .ADDR_BITS(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_instr_i    (mem_instr_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_pc_i       (mem_pc_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_addr_err_o (mem_addr_err_o),
    .wr_valid_o     (wr_valid_o),
    .wr_pc_o        (wr_pc_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one access against the model memory as it is now
  task automatic modelAccess(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err,
                             output logic commit, output logic [31:0] newword);
    bit is_ld, is_st, sgn;
    int size;
    longint unsigned mask, word, raw, shift;
    is_ld = (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    is_st = (op == SW) || (op == SH) || (op == SB);
    sgn   = (op == LH) || (op == LB);
    size  = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    err   = (is_ld || is_st) && ((addr >= DEPTH * 4) || (addr % size != 0));
    rd = 0; commit = 0; newword = 0;
    if (!err && (is_ld || is_st)) begin
      word  = longint'(model_mem[addr / 4]);
      shift = (addr % 4) * 8;
      mask  = (64'd1 << (8 * size)) - 1;
      if (is_ld) begin
        raw = (word >> shift) & mask;
        if (sgn && raw[8 * size - 1]) raw = raw | (~mask);
        rd = raw[31:0];
      end else begin
        raw = (word & ~(mask << shift)) | ((longint'(wdata) & mask) << shift);
        newword = raw[31:0];
        commit = 1;
      end
    end
  endtask

  // Drive one cycle, check combinational outputs, then the trace after the edge
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] pc,
                               input logic rst);
    logic [31:0] rd, nw;
    logic err, commit;
    @(negedge clk);
    reset       = rst;
    mem_instr_i = {op, 26'($urandom)};
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_pc_i    = pc;
    #1;
    modelAccess(op, addr, wdata, rd, err, commit, nw);
    obs_rdata = mem_rdata_o;
    obs_err   = mem_addr_err_o;
    checkOutput("rdata", mem_rdata_o, rd);
    checkOutput("addr_err", 32'(mem_addr_err_o), 32'(err));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
      exp_valid = 0; exp_pc = 0; exp_addr = 0; exp_data = 0;
    end else if (commit) begin
      model_mem[addr / 4] = nw;
      exp_valid = 1; exp_pc = pc; exp_addr = addr & 32'hFFFF_FFFC; exp_data = nw;
    end else begin
      exp_valid = 0;
    end
    #1;
    if (wr_valid_o) valid_pulses++;
    checkOutput("wr_valid", 32'(wr_valid_o), 32'(exp_valid));
    checkOutput("wr_pc", wr_pc_o, exp_pc);
    checkOutput("wr_addr", wr_addr_o, exp_addr);
    checkOutput("wr_data", wr_data_o, exp_data);
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] addr;
    vectors = 0; miscompares = 0; valid_pulses = 0;
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'b000000, 6'b001000};
    reset = 1'b1; mem_instr_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_pc_i = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    exp_valid = 0; exp_pc = 0; exp_addr = 0; exp_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(wr_valid_o), 32'h0);
    checkOutput("reset_data", wr_data_o, 32'h0);

    // Word store then load, with trace
    applyStimulus(SW, 32'h10, 32'h1234_5678, 32'h0040_0100, 0);
    checkOutput("plan_sw_trace_data", wr_data_o, 32'h1234_5678);
    checkOutput("plan_sw_trace_addr", wr_addr_o, 32'h10);
    applyStimulus(LW, 32'h10, 0, 32'h0040_0104, 0);
    checkOutput("plan_lw", obs_rdata, 32'h1234_5678);

    // Byte store and extended byte loads
    applyStimulus(SB, 32'h13, 32'hFFFF_FFAB, 32'h0040_0108, 0);
    applyStimulus(LB, 32'h13, 0, 32'h0040_010C, 0);
    checkOutput("plan_lb", obs_rdata, 32'hFFFF_FFAB);
    applyStimulus(LBU, 32'h13, 0, 32'h0040_0110, 0);
    checkOutput("plan_lbu", obs_rdata, 32'h0000_00AB);
    applyStimulus(LW, 32'h10, 0, 32'h0040_0114, 0);
    checkOutput("plan_lw_merged", obs_rdata, 32'hAB34_5678);

    // Halfword store and extended halfword loads
    applyStimulus(SH, 32'h22, 32'h0000_8001, 32'h0040_0118, 0);
    applyStimulus(LH, 32'h22, 0, 0, 0);
    checkOutput("plan_lh", obs_rdata, 32'hFFFF_8001);
    applyStimulus(LHU, 32'h22, 0, 0, 0);
    checkOutput("plan_lhu", obs_rdata, 32'h0000_8001);
    applyStimulus(LH, 32'h20, 0, 0, 0);
    checkOutput("plan_lh_low", obs_rdata, 32'h0);

    // Misaligned and out-of-range accesses
    applyStimulus(SW, 32'h11, 32'hDEAD_BEEF, 32'h0040_0200, 0);
    checkOutput("plan_sw_mis_err", 32'(obs_err), 32'h1);
    checkOutput("plan_sw_mis_novalid", 32'(wr_valid_o), 32'h0);
    applyStimulus(LW, 32'h10, 0, 0, 0);
    checkOutput("plan_mem_unchanged", obs_rdata, 32'hAB34_5678);
    applyStimulus(LW, 32'h1000, 0, 0, 0);
    checkOutput("plan_oor_err", 32'(obs_err), 32'h1);
    checkOutput("plan_oor_rdata", obs_rdata, 32'h0);

    // Fill words 0..3, then reset while a store is presented
    for (int i = 0; i < 4; i++)
      applyStimulus(SW, 32'(4 * i), 32'hA5A5_0000 + 32'(i + 1), 32'h100 + 32'(i), 0);
    applyStimulus(SW, 32'h4, 32'hFFFF_FFFF, 32'h200, 1);
    applyStimulus(6'b000000, 0, 0, 0, 1);
    checkOutput("plan_rst_trace_pc", wr_pc_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(LW, 32'(4 * i), 0, 0, 0);
      checkOutput("plan_rst_lw", obs_rdata, 32'h0);
    end

    // Back-to-back byte stores into all four lanes
    valid_pulses = 0;
    applyStimulus(SB, 32'h40, 32'h11, 32'h300, 0);
    applyStimulus(SB, 32'h41, 32'h22, 32'h304, 0);
    applyStimulus(SB, 32'h42, 32'h33, 32'h308, 0);
    applyStimulus(SB, 32'h43, 32'h44, 32'h30C, 0);
    checkOutput("plan_sb_last_data", wr_data_o, 32'h4433_2211);
    checkOutput("plan_sb_pulses", 32'(valid_pulses), 32'd4);
    applyStimulus(LW, 32'h40, 0, 0, 0);
    checkOutput("plan_sb_lw", obs_rdata, 32'h4433_2211);

    // Random traffic over a small window so loads hit recently stored words
    for (int n = 0; n < 600; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      addr = 32'($urandom_range(0, 127));
      case ($urandom_range(0, 19))
        0: addr = 32'h1000 + 32'($urandom_range(0, 255));
        1: addr = $urandom;
        2: addr = 32'(DEPTH * 4 - 4) + 32'($urandom_range(0, 3));
        default: begin end
      endcase
      applyStimulus(op, addr, $urandom, $urandom, ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
